// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file widths and write-arbiter state encoding
package regfile_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 4;
  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Round-robin pointer values: which requester wins the next tie.
  localparam logic RR_A = 1'b0;
  localparam logic RR_B = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant with pointer register
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (ptr_q == RR_B) ? 2'b10 : 2'b01;
    end
  end

  // After a transfer the other requester wins the next tie.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = gnt[0] ? RR_B : RR_A;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= RR_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - register-file write port owner: reset clear, then A/B round-robin
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  reg_write_enable,
  output logic [ADDR_WIDTH-1:0] reg_write_address_in,
  output logic [DATA_WIDTH-1:0] reg_write_data_in,
  output logic                  init_done
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  // One extra counter bit lets "all registers cleared" be told apart from address 0.
  localparam logic [ADDR_WIDTH:0] CLEAR_END = (ADDR_WIDTH + 1)'(NUM_REGS);
  localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH + 1)'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  init_done_q, init_done_d;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       advance;

  assign req     = (state_q == ST_RUN) ? {b_valid, a_valid} : 2'b00;
  assign advance = |gnt;

  rr_arbiter2 u_rr_arbiter2 (
    .clk     (clk),
    .rst_n   (reset),
    .req     (req),
    .advance (advance),
    .gnt     (gnt)
  );

  assign a_ready = gnt[0];
  assign b_ready = gnt[1];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == CLEAR_END) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end else begin
          we_d   = 1'b1;
          addr_d = cnt_q[ADDR_WIDTH-1:0];
          data_d = INIT_VALUE;
          cnt_d  = cnt_q + CNT_ONE;
        end
      end
      ST_RUN: begin
        if (gnt[0]) begin
          we_d   = 1'b1;
          addr_d = a_addr;
          data_d = a_data;
        end else if (gnt[1]) begin
          we_d   = 1'b1;
          addr_d = b_addr;
          data_d = b_data;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      init_done_q <= init_done_d;
    end
  end

  assign reg_write_enable     = we_q;
  assign reg_write_address_in = addr_q;
  assign reg_write_data_in    = data_q;
  assign init_done            = init_done_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - scoreboard bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  logic       clk;
  logic       reset;
  logic       a_valid, b_valid;
  logic       a_ready, b_ready;
  logic [3:0] a_addr, b_addr;
  logic [7:0] a_data, b_data;
  logic       reg_write_enable;
  logic [3:0] reg_write_address_in;
  logic [7:0] reg_write_data_in;
  logic       init_done;

  int vectors     = 0;
  int miscompares = 0;
  int writes_seen = 0;
  int base_writes;

  logic [11:0] exp_q [$];
  logic [11:0] mon_e;
  logic [7:0]  mem [16];
  logic        turn_a;

  regfile_write_arbiter dut (
    .clk                  (clk),
    .reset                (reset),
    .a_valid              (a_valid),
    .a_ready              (a_ready),
    .a_addr               (a_addr),
    .a_data               (a_data),
    .b_valid              (b_valid),
    .b_ready              (b_ready),
    .b_addr               (b_addr),
    .b_data               (b_data),
    .reg_write_enable     (reg_write_enable),
    .reg_write_address_in (reg_write_address_in),
    .reg_write_data_in    (reg_write_data_in),
    .init_done            (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_clear(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({4'(i), 8'h00});
  endtask

  // Register-file model and write scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (reg_write_enable === 1'b1) begin
      writes_seen++;
      mem[reg_write_address_in] = reg_write_data_in;
      chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("write_addr_data", {20'd0, reg_write_address_in, reg_write_data_in}, {20'd0, mon_e});
      end
    end
  end

  task automatic full_clear();
    push_clear(16);
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("clear_init_done_low", init_done, 1'b0);
      chk("clear_a_ready_low", a_ready, 1'b0);
    end
    tick();
    chk("init_done_rise", init_done, 1'b1);
    chk("after_clear_we_low", reg_write_enable, 1'b0);
    chk("clear_queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset   = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1;
    a_addr  = '0;   b_addr  = '0;
    a_data  = '0;   b_data  = '0;
    tick();
    tick();
    chk("rst_we", reg_write_enable, 1'b0);
    chk("rst_addr", 32'(reg_write_address_in), 32'd0);
    chk("rst_data", 32'(reg_write_data_in), 32'd0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_a_ready", a_ready, 1'b0);
    chk("rst_b_ready", b_ready, 1'b0);
    a_valid = 1'b0; b_valid = 1'b0;

    full_clear();
    for (int i = 0; i < 16; i++) chk("clear_readback", 32'(mem[i]), 32'd0);

    // Contention from the first RUN cycle: A wins, then B.
    a_valid = 1'b1; a_addr = 4'd15; a_data = 8'd16;
    b_valid = 1'b1; b_addr = 4'd10; b_data = 8'd255;
    #1;
    chk("cont_a_ready", a_ready, 1'b1);
    chk("cont_b_wait", b_ready, 1'b0);
    exp_q.push_back({4'd15, 8'd16});
    tick();
    a_valid = 1'b0;
    #1;
    chk("cont_b_ready", b_ready, 1'b1);
    chk("cont_a_idle", a_ready, 1'b0);
    exp_q.push_back({4'd10, 8'd255});
    tick();
    b_valid = 1'b0;
    tick();
    tick();
    chk("cont_reg15", 32'(mem[15]), 32'd16);
    chk("cont_reg10", 32'(mem[10]), 32'd255);

    // Single requester A.
    a_valid = 1'b1; a_addr = 4'd3; a_data = 8'd4;
    #1;
    chk("single_a_ready", a_ready, 1'b1);
    chk("single_b_ready", b_ready, 1'b0);
    exp_q.push_back({4'd3, 8'd4});
    tick();
    a_valid = 1'b0;
    chk("single_strobe", reg_write_enable, 1'b1);
    tick();
    tick();
    chk("single_reg3", 32'(mem[3]), 32'd4);

    // Lone B write hands the tie-break back to A.
    b_valid = 1'b1; b_addr = 4'd7; b_data = 8'h77;
    #1;
    chk("lone_b_ready", b_ready, 1'b1);
    exp_q.push_back({4'd7, 8'h77});
    tick();
    b_valid = 1'b0;

    // Same address from both, A first.
    a_valid = 1'b1; a_addr = 4'd5; a_data = 8'd1;
    b_valid = 1'b1; b_addr = 4'd5; b_data = 8'd2;
    #1;
    chk("same_a_first", a_ready, 1'b1);
    chk("same_b_waits", b_ready, 1'b0);
    exp_q.push_back({4'd5, 8'd1});
    tick();
    a_valid = 1'b0;
    #1;
    chk("same_b_second", b_ready, 1'b1);
    exp_q.push_back({4'd5, 8'd2});
    tick();
    b_valid = 1'b0;
    tick();
    tick();
    chk("same_reg5", 32'(mem[5]), 32'd2);

    // Sustained contention for 8 cycles.
    base_writes = writes_seen;
    a_valid = 1'b1; a_addr = 4'd1; a_data = 8'hA0;
    b_valid = 1'b1; b_addr = 4'd2; b_data = 8'hB0;
    turn_a  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("sust_a_ready", a_ready, turn_a);
      chk("sust_b_ready", b_ready, !turn_a);
      chk("sust_one_ready", a_ready & b_ready, 1'b0);
      exp_q.push_back(turn_a ? {a_addr, a_data} : {b_addr, b_data});
      tick();
      if (turn_a) a_data = a_data + 8'd1;
      else        b_data = b_data + 8'd1;
      turn_a = !turn_a;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    tick();
    chk("sust_strobes", 32'(writes_seen - base_writes), 32'd8);
    chk("idle_we_low", reg_write_enable, 1'b0);
    chk("idle_addr_hold", 32'(reg_write_address_in), 32'd2);
    chk("idle_data_hold", 32'(reg_write_data_in), 32'hB3);
    chk("sust_queue_drained", 32'(exp_q.size()), 32'd0);

    // Reset while a RUN write strobe is on the outputs; the write is dropped.
    a_valid = 1'b1; a_addr = 4'd9; a_data = 8'h99;
    #1;
    chk("mid_a_ready", a_ready, 1'b1);
    tick();
    a_valid = 1'b0;
    chk("mid_strobe_up", reg_write_enable, 1'b1);
    reset = 1'b0;
    #1;
    chk("mid_rst_we", reg_write_enable, 1'b0);
    chk("mid_rst_addr", 32'(reg_write_address_in), 32'd0);
    chk("mid_rst_data", 32'(reg_write_data_in), 32'd0);
    chk("mid_rst_init_done", init_done, 1'b0);
    tick();

    // Partial clear interrupted once cnt has reached 7.
    push_clear(6);
    reset = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("part_addr6", 32'(reg_write_address_in), 32'd6);
    reset = 1'b0;
    #1;
    chk("part_rst_we", reg_write_enable, 1'b0);
    chk("part_rst_addr", 32'(reg_write_address_in), 32'd0);
    chk("part_queue_drained", 32'(exp_q.size()), 32'd0);
    tick();

    full_clear();
    for (int i = 0; i < 16; i++) chk("reclear_readback", 32'(mem[i]), 32'd0);
    tick();
    chk("final_no_extra_writes", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
